// File: rtl/dmem_arb.sv
// Two-port round-robin arbiter in front of a single-port word memory, with read-modify-write for byte writes.
// Latency: grant is combinational; rvalid 2 cycles after grant (3 cycles for partial byte-enable writes).
// Backpressure: requests are held until gnt; no grant is issued while an access is in flight.
module dmem_arb #(
   parameter logic RR_INIT = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0,
   input  logic        req1,
   input  logic        we0,
   input  logic        we1,
   input  logic [31:0] addr0,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   input  logic [3:0]  be0,
   input  logic [3:0]  be1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        rvalid0,
   output logic        rvalid1,
   output logic [31:0] rdata0,
   output logic [31:0] rdata1,
   output logic        busy,
   output logic        mem_re,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RMW    = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic        r_ptr;
   logic        r_owner;
   logic        r_we;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_be;
   logic [31:0] r_merge;
   logic [31:0] r_rdata0;
   logic [31:0] r_rdata1;
   logic        r_rvalid0;
   logic        r_rvalid1;

   logic        w_gnt0;
   logic        w_gnt1;
   logic        w_mem_re;
   logic        w_mem_we;
   logic        w_done;
   logic [31:0] w_merge;
   logic        w_unused_addr_lsb;

   // Byte offsets are meaningless for a word memory; they are dropped at latch time.
   assign w_unused_addr_lsb = ^{addr0[1:0], addr1[1:0]};

   // Next-state, grant and memory strobes; grants are only issued from IDLE and never during reset.
   always_comb begin
      w_state_nxt = r_state;
      w_gnt0      = 1'b0;
      w_gnt1      = 1'b0;
      w_mem_re    = 1'b0;
      w_mem_we    = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         IDLE: begin
            w_gnt0 = rst_n & req0 & (~req1 | ~r_ptr);
            w_gnt1 = rst_n & req1 & (~req0 |  r_ptr);
            if (w_gnt0 | w_gnt1) begin
               w_state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            w_mem_re = 1'b1;
            if (r_we && (r_be == 4'hF)) begin
               w_mem_we    = 1'b1;
               w_done      = 1'b1;
               w_state_nxt = IDLE;
            end else if (r_we && (r_be != 4'h0)) begin
               w_state_nxt = RMW;
            end else begin
               // reads and empty-mask writes finish without touching memory contents
               w_done      = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         RMW: begin
            w_mem_we    = 1'b1;
            w_done      = 1'b1;
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Merge word for partial writes: enabled bytes from the request, the rest from the current memory word.
   always_comb begin
      w_merge = mem_rdata;
      for (int n = 0; n < 4; n++) begin
         if (r_be[n]) begin
            w_merge[8*n +: 8] = r_wdata[8*n +: 8];
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Request latch and round-robin pointer; the pointer moves to the other port on every grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr   <= RR_INIT;
         r_owner <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= 32'h0;
         r_wdata <= 32'h0;
         r_be    <= 4'h0;
      end else if (w_gnt0 | w_gnt1) begin
         r_ptr   <= w_gnt0;
         r_owner <= w_gnt1;
         r_we    <= w_gnt1 ? we1 : we0;
         r_addr  <= w_gnt1 ? {addr1[31:2], 2'b00} : {addr0[31:2], 2'b00};
         r_wdata <= w_gnt1 ? wdata1 : wdata0;
         r_be    <= w_gnt1 ? be1 : be0;
      end
   end

   // Merge word is captured during the read half of a partial write and replayed in RMW.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_merge <= 32'h0;
      end else if ((r_state == ACCESS) && r_we && (r_be != 4'hF)) begin
         r_merge <= w_merge;
      end
   end

   // Read data is captured only on read completions, so write completions leave rdata untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata0 <= 32'h0;
         r_rdata1 <= 32'h0;
      end else if ((r_state == ACCESS) && !r_we) begin
         if (r_owner) begin
            r_rdata1 <= mem_rdata;
         end else begin
            r_rdata0 <= mem_rdata;
         end
      end
   end

   // One-cycle completion pulse to the owning port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rvalid0 <= 1'b0;
         r_rvalid1 <= 1'b0;
      end else begin
         r_rvalid0 <= w_done & ~r_owner;
         r_rvalid1 <= w_done &  r_owner;
      end
   end

   assign gnt0      = w_gnt0;
   assign gnt1      = w_gnt1;
   assign rvalid0   = r_rvalid0;
   assign rvalid1   = r_rvalid1;
   assign rdata0    = r_rdata0;
   assign rdata1    = r_rdata1;
   assign busy      = (r_state != IDLE);
   assign mem_re    = w_mem_re;
   assign mem_we    = w_mem_we;
   assign mem_addr  = r_addr;
   assign mem_wdata = (r_state == RMW) ? r_merge : r_wdata;

endmodule

// File: tb/tb_dmem_arb.sv
// Testbench for dmem_arb: directed scenarios followed by randomized two-port traffic.
// Expected behaviour comes from a transaction-level model (grant cycle + fixed latency, reference memory).
// Requests are held until the model predicts a grant, then dropped and their fields scrambled.
module tb_dmem_arb;

   localparam logic RR_INIT = 1'b0;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0, req1, we0, we1;
   logic [31:0] addr0, addr1, wdata0, wdata1;
   logic [3:0]  be0, be1;
   logic        gnt0, gnt1, rvalid0, rvalid1, busy, mem_re, mem_we;
   logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

   logic [31:0] mem     [0:255];
   logic [31:0] ref_mem [0:255];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // transaction-level model of the single in-flight access
   bit          m_pend;
   bit          m_we;
   bit          m_ptr;
   int          m_owner, m_grant, m_lat;
   logic [31:0] m_addr, m_word, m_old, m_rd;
   logic [3:0]  m_be;
   logic [31:0] exp_rd [0:1];
   logic        m_g0, m_g1;

   // DUT snapshots taken at the checking point of the last cycle
   logic        s_g0, s_g1, s_rv0, s_rv1, s_we;
   logic [31:0] s_addr, s_wdata, s_rd0, s_rd1;

   int          lat, nwe;
   logic [31:0] wl, fa;

   always #5 clk = ~clk;

   dmem_arb #(.RR_INIT(RR_INIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .be0(be0), .be1(be1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
      .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // word memory attached to the DUT
   assign mem_rdata = mem_re ? mem[mem_addr[9:2]] : 32'h0;
   always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] = mem_wdata;

   function automatic logic [31:0] merge(input logic [31:0] nw, input logic [31:0] old, input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int n = 0; n < 4; n++) if (be[n]) r[8*n +: 8] = nw[8*n +: 8];
      return r;
   endfunction

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic preload(input int idx, input logic [31:0] v);
      mem[idx]     = v;
      ref_mem[idx] = v;
   endtask

   // One clock cycle: check DUT against the model at the negedge, advance the model, step past the next posedge.
   task automatic cycle();
      int   ph;
      int   p;
      bit   free;
      logic e_rv0, e_rv1, e_re, e_we, e_busy;
      @(negedge clk);
      s_g0 = gnt0; s_g1 = gnt1; s_rv0 = rvalid0; s_rv1 = rvalid1; s_we = mem_we;
      s_addr = mem_addr; s_wdata = mem_wdata; s_rd0 = rdata0; s_rd1 = rdata1;
      free = !m_pend || (cyc >= m_grant + m_lat);
      m_g0 = free && req0 && (!req1 || (m_ptr == 1'b0));
      m_g1 = free && req1 && !m_g0;
      chk1("gnt0", gnt0, m_g0);
      chk1("gnt1", gnt1, m_g1);
      e_rv0 = 1'b0; e_rv1 = 1'b0; e_re = 1'b0; e_we = 1'b0; e_busy = 1'b0;
      if (m_pend) begin
         ph     = cyc - m_grant;
         e_busy = (ph < m_lat);
         e_re   = (ph == 1);
         e_we   = ((ph == 1) && m_we && (m_be == 4'hF)) || ((ph == 2) && (m_lat == 3));
         if (ph >= 1 && ph < m_lat) chk32("mem_addr", mem_addr, {m_addr[31:2], 2'b00});
         if (e_we) chk32("mem_wdata", mem_wdata, m_word);
         if (ph == m_lat) begin
            if (m_owner == 0) e_rv0 = 1'b1; else e_rv1 = 1'b1;
            if (!m_we) exp_rd[m_owner] = m_rd;
            chk32("mem_word", mem[m_addr[9:2]], ref_mem[m_addr[9:2]]);
         end
      end
      chk1("rvalid0", rvalid0, e_rv0);
      chk1("rvalid1", rvalid1, e_rv1);
      chk1("mem_re", mem_re, e_re);
      chk1("mem_we", mem_we, e_we);
      chk1("busy", busy, e_busy);
      chk32("rdata0", rdata0, exp_rd[0]);
      chk32("rdata1", rdata1, exp_rd[1]);
      if (m_g0 || m_g1) begin
         p       = m_g0 ? 0 : 1;
         m_owner = p;
         m_grant = cyc;
         m_we    = (p == 1) ? we1 : we0;
         m_addr  = (p == 1) ? addr1 : addr0;
         m_be    = (p == 1) ? be1 : be0;
         m_old   = ref_mem[m_addr[9:2]];
         m_rd    = m_old;
         m_word  = merge((p == 1) ? wdata1 : wdata0, m_old, m_be);
         m_lat   = (m_we && (m_be != 4'h0) && (m_be != 4'hF)) ? 3 : 2;
         if (m_we) ref_mem[m_addr[9:2]] = m_word;
         m_pend  = 1'b1;
         m_ptr   = (p == 0);
      end else if (m_pend && (cyc >= m_grant + m_lat)) begin
         m_pend = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   // Reset asserted 2ns after a rising edge (mid-cycle), checked, released 1ns after the next edge.
   task automatic do_reset();
      #1 rst_n = 1'b0;
      req0 = 1'b1; req1 = 1'b1;
      @(negedge clk);
      chk1("rst_gnt0", gnt0, 1'b0);
      chk1("rst_gnt1", gnt1, 1'b0);
      chk1("rst_rvalid0", rvalid0, 1'b0);
      chk1("rst_rvalid1", rvalid1, 1'b0);
      chk1("rst_mem_we", mem_we, 1'b0);
      chk1("rst_mem_re", mem_re, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk32("rst_rdata0", rdata0, 32'h0);
      chk32("rst_rdata1", rdata1, 32'h0);
      chk32("rst_mem_addr", mem_addr, 32'h0);
      chk32("rst_mem_wdata", mem_wdata, 32'h0);
      if (m_pend && m_we && (cyc < m_grant + m_lat)) ref_mem[m_addr[9:2]] = m_old;
      m_pend    = 1'b0;
      m_ptr     = RR_INIT;
      exp_rd[0] = 32'h0;
      exp_rd[1] = 32'h0;
      @(posedge clk);
      #1;
      req0 = 1'b0; req1 = 1'b0;
      rst_n = 1'b1;
      cyc++;
   endtask

   // Single access from an idle DUT; reports latency, mem_we count, last write word and first access address.
   task automatic xact(input int p, input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, output int l, output int nw, output logic [31:0] lw,
                       output logic [31:0] first_addr);
      if (p == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd; be0 = be; end
      else        begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd; be1 = be; end
      cycle();
      chk1("xact_gnt", (p == 0) ? s_g0 : s_g1, 1'b1);
      req0 = 1'b0; req1 = 1'b0;
      l = 0; nw = 0; lw = 32'h0; first_addr = 32'h0;
      for (int k = 0; k < 6; k++) begin
         cycle();
         l++;
         if (k == 0) first_addr = s_addr;
         if (s_we) begin nw++; lw = s_wdata; end
         if ((p == 0) ? s_rv0 : s_rv1) break;
      end
   endtask

   task automatic rand_fields(input int p);
      logic [3:0] b;
      case ($urandom_range(0, 3))
         0:       b = 4'h0;
         1:       b = 4'hF;
         default: b = 4'($urandom);
      endcase
      if (p == 0) begin
         we0 = 1'($urandom); addr0 = {22'd0, 8'($urandom_range(0, 15)), 2'($urandom)};
         wdata0 = $urandom; be0 = b;
      end else begin
         we1 = 1'($urandom); addr1 = {22'd0, 8'($urandom_range(0, 15)), 2'($urandom)};
         wdata1 = $urandom; be1 = b;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = 32'h0; addr1 = 32'h0; wdata0 = 32'h0; wdata1 = 32'h0; be0 = 4'h0; be1 = 4'h0;
      for (int i = 0; i < 256; i++) begin
         mem[i]     = $urandom;
         ref_mem[i] = mem[i];
      end
      m_pend = 1'b0; m_ptr = RR_INIT; exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
      do_reset();
      idle(2);

      // read with unaligned byte address
      preload(4, 32'hDEADBEEF);
      xact(0, 1'b0, 32'h13, 32'h0, 4'h0, lat, nwe, wl, fa);
      chk32("read_mem_addr", fa, 32'h10);
      chk32("read_latency", 32'(lat), 32'd2);
      chk32("read_rdata0", s_rd0, 32'hDEADBEEF);

      // partial write goes through read-modify-write
      preload(8, 32'h11223344);
      xact(1, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, lat, nwe, wl, fa);
      chk32("pw_latency", 32'(lat), 32'd3);
      chk32("pw_nwe", 32'(nwe), 32'd1);
      chk32("pw_wdata", wl, 32'h11BB33DD);
      chk32("pw_mem", mem[8], 32'h11BB33DD);

      // contention: both ports hold reads, grants alternate starting from RR_INIT
      do_reset();
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
      req1 = 1'b1; we1 = 1'b0; addr1 = 32'h20;
      for (int i = 0; i < 8; i++) begin
         cycle();
         chk32("rr_gnt", {30'd0, s_g1, s_g0}, (i % 2 == 1) ? 32'd0 : ((i % 4 == 0) ? 32'd1 : 32'd2));
      end
      req0 = 1'b0; req1 = 1'b0;
      idle(3);

      // empty-mask write leaves memory alone; full write updates it; rdata untouched by writes
      preload(12, 32'h5);
      xact(1, 1'b1, 32'h30, 32'hFFFFFFFF, 4'h0, lat, nwe, wl, fa);
      chk32("be0_latency", 32'(lat), 32'd2);
      chk32("be0_nwe", 32'(nwe), 32'd0);
      chk32("be0_mem", mem[12], 32'h5);
      chk32("be0_rdata1", rdata1, 32'h11BB33DD);
      xact(0, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF, lat, nwe, wl, fa);
      chk32("full_nwe", 32'(nwe), 32'd1);
      chk32("full_mem", mem[12], 32'hCAFEF00D);
      chk32("full_rdata0", rdata0, 32'hDEADBEEF);

      // reset in the RMW cycle aborts the write
      preload(16, 32'h01020304);
      req0 = 1'b1; we0 = 1'b1; addr0 = 32'h40; wdata0 = 32'hFFFFFFFF; be0 = 4'b0011;
      cycle();
      chk1("abort_gnt0", s_g0, 1'b1);
      req0 = 1'b0;
      cycle();
      do_reset();
      idle(2);
      chk32("abort_mem", mem[16], 32'h01020304);
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h40;
      req1 = 1'b1; we1 = 1'b0; addr1 = 32'h44;
      cycle();
      chk32("abort_rr", {30'd0, s_g1, s_g0}, 32'd1);
      req0 = 1'b0;
      for (int k = 0; k < 6; k++) begin
         cycle();
         if (m_g1) begin req1 = 1'b0; break; end
      end
      req1 = 1'b0;
      idle(4);

      // randomized traffic on both ports, with one reset in the middle
      rand_fields(0);
      rand_fields(1);
      for (int i = 0; i < 800; i++) begin
         if (i == 400) do_reset();
         if (!req0 && ($urandom_range(0, 2) != 0)) begin rand_fields(0); req0 = 1'b1; end
         if (!req1 && ($urandom_range(0, 2) != 0)) begin rand_fields(1); req1 = 1'b1; end
         cycle();
         if (m_g0) begin req0 = 1'b0; rand_fields(0); end
         if (m_g1) begin req1 = 1'b0; rand_fields(1); end
      end
      req0 = 1'b0; req1 = 1'b0;
      idle(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_arb.md
DMEM_ARB -- requirements
Module: dmem_arb

Interface
REQ-001 Parameter RR_INIT, default 0: port (0 or 1) holding arbitration priority after reset.
REQ-002 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset; SHALL be asynchronous and active-low.
REQ-004 req0, req1  input  1 each  access request, held until granted.
REQ-005 we0, we1  input  1 each  1 = write, 0 = read; sampled at grant.
REQ-006 addr0, addr1  input  32 each  byte address; addr[1:0] ignored.
REQ-007 wdata0, wdata1  input  32 each  write data; sampled at grant.
REQ-008 be0, be1  input  4 each  byte enables for writes (bit n = byte n); sampled at grant.
REQ-009 gnt0, gnt1  output  1 each  combinational grant; request accepted in a cycle where req and gnt are both 1.
REQ-010 rvalid0, rvalid1  output  1 each  registered one-cycle completion pulse, for reads and writes.
REQ-011 rdata0, rdata1  output  32 each  registered read data, held until the next read completion on that port.
REQ-012 busy  output  1  1 when state is not IDLE.
REQ-013 mem_re, mem_we  output  1 each  word-memory read and write enables.
REQ-014 mem_addr  output  32  latched address with bits [1:0] forced to 0.
REQ-015 mem_wdata  output  32  word-memory write data.
REQ-016 mem_rdata  input  32  word-memory read data, combinational from mem_addr when mem_re = 1.

Function
REQ-017 FSM states SHALL be IDLE, ACCESS and RMW; reset state SHALL be IDLE.
REQ-018 In IDLE, gnt SHALL go to the single requesting port; if both request, it SHALL go to the port named by the priority pointer; no gnt SHALL assert outside IDLE.
REQ-019 At most one of gnt0 and gnt1 SHALL be 1 in any cycle.
REQ-020 On a grant, the block SHALL latch owner, we, addr, wdata and be, flip the priority pointer to the other port, and enter ACCESS.
REQ-021 With no request in IDLE, the pointer and state SHALL remain unchanged.
REQ-022 ACCESS: mem_re = 1 and mem_addr = latched address.
REQ-023 ACCESS read: the block SHALL register mem_rdata into the owner's rdata, pulse the owner's rvalid next cycle, and return to IDLE.
REQ-024 ACCESS write with be = 4'b1111: mem_we = 1, mem_wdata = latched wdata, owner's rvalid pulses next cycle, return to IDLE.
REQ-025 ACCESS write with be = 4'b0000: no mem_we, owner's rvalid pulses next cycle, return to IDLE.
REQ-026 ACCESS write with partial be: the block SHALL register the merge (byte n from wdata if be[n] = 1, else from mem_rdata) and enter RMW.
REQ-027 RMW: mem_we = 1, mem_wdata = registered merge word, mem_addr unchanged; owner's rvalid pulses next cycle; return to IDLE.
REQ-028 Latency from the grant cycle T: read and full or empty write SHALL have rvalid at T+2; partial write SHALL have rvalid at T+3.
REQ-029 A new grant SHALL be possible in the cycle rvalid is high (back-to-back: one access per 2 cycles, or 3 for partial writes).
REQ-030 mem_we and mem_re SHALL be 0 in IDLE; mem_we SHALL be 1 only in the cases of REQ-024 and REQ-027.
REQ-031 Write completions SHALL NOT alter rdata; only the owner's rvalid SHALL pulse.
REQ-032 Request inputs that change after the grant SHALL NOT affect an in-flight access.

Reset
REQ-033 While rst_n = 0, outputs SHALL be: gnt, rvalid, mem_we, mem_re and busy = 0; rdata0, rdata1, mem_addr and mem_wdata = 0.
REQ-034 During reset, the priority pointer SHALL equal RR_INIT and the state SHALL be IDLE.
REQ-035 Reset asserted mid-access SHALL abort it: no memory write, no rvalid after reset release, and all latched fields cleared.

Verification
REQ-036 Read: preload word 0x10 = 0xDEADBEEF; req0 read at addr 0x13 -> gnt0 at T, mem_addr = 0x10, rvalid0 at T+2 with rdata0 = 0xDEADBEEF.
REQ-037 Partial write: word 0x20 = 0x11223344; req1 write wdata = 0xAABBCCDD, be = 4'b0101 -> RMW writes 0x11BB33DD, rvalid1 at T+3.
REQ-038 Contention, RR_INIT = 0: both ports hold reads continuously -> grants alternate 0, 1, 0, 1 at cycles T, T+2, T+4, T+6; gnt is never high for both ports.
REQ-039 be = 0 write: word 0x30 = 0x5 -> no mem_we, rvalid pulses, word still 0x5; full write 0xCAFEF00D -> memory updated, rdata unchanged.
REQ-040 Reset during RMW: rst_n low in the RMW cycle -> mem_we = 0, no rvalid, memory word unchanged, busy = 0, next grant follows RR_INIT.
